// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the EX/MEM capture payload.
package cpu_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 6;
    localparam int unsigned DMEM_DEPTH = 256;

    // Condition flag values after reset
    localparam logic ZERO_RST = 1'b0;
    localparam logic NEG_RST  = 1'b0;

    // Everything the memory/write-back end captures from execute
    typedef struct packed {
        logic [DATA_W-1:0]     aluout;
        logic [DATA_W-1:0]     rd2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regw;
        logic                  memw;
        logic                  memr;
        logic                  flagw;
        logic                  zero;
        logic                  neg;
    } exmem_t;

endpackage

// File: rtl/dmem.sv
// Data memory: synchronous write, combinational read, no reset.
module dmem
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH  = DMEM_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write lands on the rising edge; a read in the same cycle sees the old word
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata_c = mem[addr];

endmodule

// File: rtl/stage_wb.sv
// Memory-access / write-back pipeline end: EX/MEM capture, data memory,
// MEM/WB buffer driving the register-file write port and condition flags.
// Optional build macro WB_R0_ZERO_EN: suppress register-file writes to r0.
module stage_wb
    import cpu_pkg::*;
#(
    parameter int unsigned DMEM_DEPTH = cpu_pkg::DMEM_DEPTH,
    parameter int unsigned ADDR_W     = $clog2(DMEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     in_aluout,
    input  logic [DATA_W-1:0]     in_rd2,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_regw,
    input  logic                  in_memw,
    input  logic                  in_memr,
    input  logic                  in_flagw,
    input  logic                  in_zero,
    input  logic                  in_neg,
    output logic                  out_regw,
    output logic [DATA_W-1:0]     out_writedata,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_zero,
    output logic                  out_neg
);

    exmem_t                ex_q;
    logic [ADDR_W-1:0]     maddr_c;
    logic [DATA_W-1:0]     mdata_c;
    logic [DATA_W-1:0]     wdata_c;
    logic                  regw_c;
    logic [DATA_W-ADDR_W-1:0] unused_hi;

    logic                  regw_q;
    logic [DATA_W-1:0]     wd_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  zero_q;
    logic                  neg_q;

    // EX/MEM capture of every incoming control and data signal
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= '{aluout: in_aluout, rd2: in_rd2, rd: in_rd,
                      regw: in_regw, memw: in_memw, memr: in_memr,
                      flagw: in_flagw, zero: in_zero, neg: in_neg};
        end
    end

    // Word index wraps modulo the memory depth; upper ALU bits are ignored
    assign maddr_c   = ex_q.aluout[ADDR_W-1:0];
    assign unused_hi = ex_q.aluout[DATA_W-1:ADDR_W];

    dmem #(
        .DEPTH  (DMEM_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dmem (
        .clk     (clk),
        .we      (ex_q.memw),
        .addr    (maddr_c),
        .wdata   (ex_q.rd2),
        .rdata_c (mdata_c)
    );

    // Write-back data select and register-write qualification
    always_comb begin
        wdata_c = ex_q.aluout;
        regw_c  = ex_q.regw;
        if (ex_q.memr) begin
            wdata_c = mdata_c;
        end
`ifdef WB_R0_ZERO_EN
        if (ex_q.rd == '0) begin
            regw_c = 1'b0;
        end
`endif
    end

    // MEM/WB buffer; write data and flags hold unless their enables are set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regw_q <= 1'b0;
            wd_q   <= '0;
            rd_q   <= '0;
            zero_q <= ZERO_RST;
            neg_q  <= NEG_RST;
        end else begin
            regw_q <= regw_c;
            rd_q   <= ex_q.rd;
            if (ex_q.regw) begin
                wd_q <= wdata_c;
            end
            if (ex_q.flagw) begin
                zero_q <= ex_q.zero;
                neg_q  <= ex_q.neg;
            end
        end
    end

    assign out_regw      = regw_q;
    assign out_writedata = wd_q;
    assign out_rd        = rd_q;
    assign out_zero      = zero_q;
    assign out_neg       = neg_q;

endmodule

// File: doc/stage_wb.md
Name: stage_wb

Overview:
Memory-access and write-back end of the CPU pipeline. Consumes the EX/MEM-side signals (ALU result, store data, destination register, control bits), performs data-memory load/store, and latches a MEM/WB buffer. It drives the register-file write port (regw, write data, rd) and the registered zero/neg condition flags that the decode stage's control unit consumes for brz/brn. It is the producer side of the decode stage's write-back interface.

Parameters:
DMEM_DEPTH, 256, number of 32-bit data-memory words (power of two)
ADDR_W, 8, word-index width = log2(DMEM_DEPTH)

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_aluout  input  32  ALU result; memory word index for loads/stores
in_rd2  input  32  store data
in_rd  input  6  destination register
in_regw  input  1  register write enable
in_memw  input  1  data-memory write enable
in_memr  input  1  load select (write back memory data instead of ALU result)
in_flagw  input  1  update condition flags from this instruction
in_zero  input  1  ALU zero result
in_neg  input  1  ALU negative result
out_regw  output  1  register-file write enable
out_writedata  output  32  register-file write data
out_rd  output  6  register-file write address
out_zero  output  1  registered zero flag
out_neg  output  1  registered negative flag

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low. Assertion clears all pipeline and flag registers immediately, with no clock edge required.
- Reset values: out_regw=0, out_writedata=0, out_rd=0, out_zero=0, out_neg=0. All internal EX/MEM capture registers are cleared to 0.
- Data memory is not reset. Its contents are undefined until written.
- Pipeline, two registered stages:
  - Edge E1 captures all in_* signals into the EX/MEM registers.
  - During the following cycle, memory is accessed using the captured values.
  - Edge E2 loads the MEM/WB registers, which drive the outputs.
  - Latency from input to output is exactly 2 cycles. Throughput is one instruction per cycle, with no stalls.
- Memory address is the word index aluout[ADDR_W-1:0]. Upper bits are ignored, so out-of-range addresses wrap modulo DMEM_DEPTH.
- Memory read is combinational from the array using the captured address. Memory write is synchronous at E2 when the captured memw=1.
- memr=1 and memw=1 in the same instruction: the write is performed, and out_writedata is the old (pre-write) word.
- Store at cycle k followed by a load to the same address at cycle k+1: the load returns the new data, because the write lands at the edge before the load's read.
- out_writedata equals the memory word if the captured memr=1, otherwise the captured aluout.
- out_regw and out_rd are the captured regw and rd, delayed one stage. out_writedata is held whenever regw=0; it carries no meaning in that case.
- Flags: at E2, if the captured flagw=1, out_zero and out_neg take the captured zero and neg. Otherwise both hold.
- Flags are independent of regw and memr.
- Reset in mid-operation: a store held in EX/MEM is dropped, since the cleared memw means no memory write occurs. After rst_n rises, the first valid output appears 2 edges after the first captured instruction.

Optional Feature:
Macro WB_R0_ZERO_EN.
- Defined: when the captured rd==0, out_regw is forced to 0 at E2, so register 0 is never written. Flags and memory still update normally.
- Undefined: rd==0 is treated like any other register.

Decomposition:
- Shared package cpu_pkg holds: DATA_W=32, REG_ADDR_W=6, default DMEM_DEPTH, and the reset values of the flags.
- One sub-module, dmem: a synchronous-write / combinational-read RAM parameterised by DMEM_DEPTH.
- The MEM/WB buffer logic stays in stage_wb, mirroring the existing ID/EX buffer style.

Test Plan:
- Reset: hold rst_n=0 mid-clock with nonzero inputs -> all outputs are 0 immediately. Release, then drive ALU op aluout=0x0000_1234, rd=5, regw=1 -> two edges later out_regw=1, out_rd=5, out_writedata=0x1234.
- Store/load back-to-back: store rd2=0xDEADBEEF at aluout=3, then load aluout=3 with rd=7, memr=1, regw=1 -> out_writedata=0xDEADBEEF, out_rd=7.
- Address wrap: store 0xA5A5A5A5 at aluout=0x103 (DEPTH 256), then load aluout=3 -> returns 0xA5A5A5A5.
- Flags: flagw=1 with zero=1, neg=0 -> out_zero=1 after 2 edges. Next instruction flagw=0 with zero=0, neg=1 -> flags hold at 1 and 0. Then flagw=1 with neg=1 -> out_neg=1 and out_zero=0.
- Reset mid-store: capture memw=1, addr 9, data 0x55, then assert rst_n before E2 -> a subsequent load from addr 9 does not return 0x55 (bench pre-writes 0x11 and expects 0x11).
- Simultaneous memr and memw at addr 4 (old content 0x22, new 0x33) -> out_writedata=0x22, and a later load returns 0x33. With WB_R0_ZERO_EN, regw=1 and rd=0 -> out_regw=0.
